// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath or a bench.
interface mips_multicycle_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              zero;
    logic              mem_ready;

    logic              pc_en;
    logic              ir_write;
    logic              i_or_d;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              alu_src_a;
    logic [1:0]        reg_dst;
    logic [1:0]        alu_src_b;
    logic [1:0]        alu_op;
    logic [1:0]        pc_source;

    logic [3:0]        state;
    logic              illegal;
    logic              instr_retired;
    logic [ADDR_W-1:0] retired_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
               alu_src_a, reg_dst, alu_src_b, alu_op, pc_source,
               state, illegal, instr_retired, retired_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
               alu_src_a, reg_dst, alu_src_b, alu_op, pc_source,
               state, illegal, instr_retired, retired_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multicycle MIPS control FSM with a sticky illegal-opcode flag
// and a retired-instruction counter.
module mips_multicycle_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        JR       = 4'd12,
        HALT     = 4'd13
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        op_q;
    logic              is_bne_q;
    logic              illegal_q;
    logic              retired_q;
    logic [ADDR_W-1:0] count_q;
    logic              retire;

    // An instruction retires on every return to FETCH; a FETCH stall does not count.
    assign retire = (state_d == FETCH) && (state_q != FETCH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            op_q      <= '0;
            is_bne_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retire;
            if (retire) begin
                count_q <= count_q + ADDR_W'(1);
            end
            if (state_d == HALT) begin
                illegal_q <= 1'b1;
            end
            if (state_q == DECODE) begin
                op_q     <= bus.opcode;
                is_bne_q <= (bus.opcode == 6'h05);
            end
        end
    end

    // NOTE: every output and state_d gets a default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d        = state_q;
        bus.pc_en      = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.pc_source  = 2'b00;

        unique case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_en    = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                unique case (bus.opcode)
                    6'h00:                      state_d = (bus.funct == 6'h08) ? JR : R_EXEC;
                    6'h23, 6'h2B:               state_d = MEM_ADDR;
                    6'h04, 6'h05:               state_d = BRANCH;
                    6'h02, 6'h03:               state_d = JUMP;
                    6'h08, 6'h0A, 6'h0C, 6'h0D: state_d = I_EXEC;
                    default:                    state_d = HALT;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (op_q == 6'h23) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = R_WB;
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
                state_d       = FETCH;
            end
            I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = 2'b11;
                state_d       = I_WB;
            end
            I_WB: begin
                bus.reg_write = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                // bne inverts the sense of the ALU zero flag.
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_source = 2'b01;
                bus.pc_en     = bus.zero ^ is_bne_q;
                state_d       = FETCH;
            end
            JUMP: begin
                bus.pc_en     = 1'b1;
                bus.pc_source = 2'b10;
                if (op_q == 6'h03) begin
                    // jal: the ALU forms PC+4 for the link write to r31.
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'b10;
                    bus.alu_src_b = 2'b01;
                end
                state_d = FETCH;
            end
            JR: begin
                bus.pc_en     = 1'b1;
                bus.pc_source = 2'b11;
                state_d       = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        // Reset kills every strobe so an aborted instruction leaves no side effect.
        if (!rst_n) begin
            bus.pc_en     = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
        end
    end

    assign bus.state         = state_q;
    assign bus.illegal       = illegal_q;
    assign bus.instr_retired = retired_q;
    assign bus.retired_count = count_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the port opcode, input, 6 bits: instruction[31:26] from the instruction parser.
REQ-005 The block SHALL have the port funct, input, 6 bits: instruction[5:0] from the parser; meaningful for R-type only.
REQ-006 The block SHALL have the port zero, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have the port mem_ready, input, 1 bit: the memory has completed the current read/write this cycle.
REQ-008 The block SHALL have the following 1-bit outputs: pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write, alu_src_a.
REQ-009 The block SHALL have the 2-bit outputs reg_dst (00 rt, 01 rd, 10 r31), alu_src_b (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2), alu_op (00 add, 01 sub, 10 use funct, 11 use opcode) and pc_source (00 ALU result, 01 ALUOut, 10 jump address, 11 reg A).
REQ-010 The block SHALL have the outputs state, 4 bits; illegal, 1 bit, sticky; instr_retired, 1-cycle pulse; and retired_count, ADDR_W bits.

Function
REQ-011 The state machine SHALL use Moore outputs; unlisted outputs are 0 in every state.
REQ-012 The states and their encodings SHALL be FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JR 12, HALT 13.
REQ-013 In FETCH the block SHALL assert mem_read, with i_or_d=0, alu_src_a=0, alu_src_b=01 and alu_op=00; while mem_ready=0 it SHALL hold FETCH with ir_write=0 and pc_en=0.
REQ-014 On the FETCH cycle in which mem_ready=1, the block SHALL assert ir_write and pc_en with pc_source=00, then go to DECODE.
REQ-015 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00, and SHALL latch is_bne=(opcode==6'h05).
REQ-016 DECODE SHALL dispatch on opcode: 0x00 with funct 0x08 to JR; 0x00 otherwise to R_EXEC; 0x23 or 0x2B to MEM_ADDR; 0x04 or 0x05 to BRANCH; 0x02 or 0x03 to JUMP; 0x08, 0x0A, 0x0C or 0x0D to I_EXEC; any other opcode to HALT.
REQ-017 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_RD if the latched opcode is 0x23, else to MEM_WR.
REQ-018 MEM_RD SHALL drive mem_read=1 and i_or_d=1, hold while mem_ready=0, and go to MEM_WB on mem_ready=1.
REQ-019 MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=00, then go to FETCH.
REQ-020 MEM_WR SHALL drive mem_write=1 and i_or_d=1, hold while mem_ready=0, and go to FETCH on mem_ready=1.
REQ-021 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to R_WB.
REQ-022 R_WB SHALL drive reg_write=1 and reg_dst=01, then go to FETCH.
REQ-023 I_EXEC SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=11, then go to I_WB.
REQ-024 I_WB SHALL drive reg_write=1 and reg_dst=00, then go to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01 and pc_en=(zero XOR is_bne), then go to FETCH.
REQ-026 JUMP SHALL drive pc_en=1 and pc_source=10; for opcode 0x03 it SHALL also drive reg_write=1, reg_dst=10, mem_to_reg=0, alu_src_a=0, alu_src_b=01 and alu_op=00, so that PC+4 is written to r31; it SHALL then go to FETCH.
REQ-027 JR SHALL drive pc_en=1 and pc_source=11, then go to FETCH.
REQ-028 HALT SHALL be absorbing, with all strobes 0; on entry illegal SHALL be set to 1, and it SHALL stay 1 until reset.
REQ-029 instr_retired SHALL pulse for exactly 1 cycle on each transition into FETCH from any state other than FETCH.
REQ-030 retired_count SHALL increment by 1 on each instr_retired pulse, wrapping modulo 2^ADDR_W.
REQ-031 Writes to memory and to the register file SHALL occur only in MEM_WR, MEM_WB, R_WB, I_WB and JUMP (jal); at most one register write SHALL occur per instruction.
REQ-032 Latency SHALL be, with memory ready immediately: lw 5 cycles, sw 4, R/I-type 4, beq/bne/j/jal/jr 3.

Reset
REQ-033 While rst_n=0 at a rising edge, the block SHALL go to state FETCH and clear illegal, is_bne, retired_count and instr_retired.
REQ-034 During reset all strobes (pc_en, ir_write, mem_read, mem_write, reg_write) SHALL be forced to 0, overriding the FETCH Moore values.
REQ-035 A reset asserted in any state, including during a stalled memory access, SHALL abort the instruction without a register or PC write and without a retire count.
REQ-036 The first FETCH after rst_n rises SHALL not pulse instr_retired.

Verification
REQ-037 The bench SHALL run lw (0x23) with mem_ready high -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1; retired_count 0->1.
REQ-038 The bench SHALL run sw (0x2B) with mem_ready low for 3 cycles in MEM_WR -> mem_write high for 4 cycles; no reg_write; returns to FETCH.
REQ-039 The bench SHALL run beq with zero=1 -> pc_en=1 with pc_source=01 in BRANCH; bne with zero=1 -> pc_en=0.
REQ-040 The bench SHALL run jal (0x03) -> JUMP drives pc_en=1, pc_source=10, reg_write=1 and reg_dst=10; jr (opcode 0, funct 0x08) -> pc_source=11 and no reg_write.
REQ-041 The bench SHALL apply opcode 0x3F -> DECODE to HALT; illegal=1 and held for 10 cycles; rst_n low 1 cycle -> FETCH, illegal=0.
REQ-042 The bench SHALL assert rst_n low during a MEM_RD stall -> next state FETCH, retired_count unchanged, no reg_write at any cycle.
